alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one `alu` datapath instance between two requesters, port 0 (integer execute stage) and port 1 (address/branch helper). It arbitrates between them, issues the winner's operation to the ALU and captures the result in a single output register. It returns the result to the issuing port with valid/ready backpressure. It sits between the issue logic and the shared ALU in the RV64I core.

## Interface
Parameters:
- `XLEN`, default 64: operand and result width; only 64 is supported.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present on port n.
- `req0_ready`, `req1_ready`  out  1  port n request accepted this cycle.
- `req0_function`, `req1_function`  in  5  ALU function code, passed unmodified to the ALU.
- `req0_a`, `req1_a`, `req0_b`, `req1_b`  in  XLEN  operands.
- `resp0_valid`, `resp1_valid`  out  1  result held for port n.
- `resp0_ready`, `resp1_ready`  in  1  port n consumes its result.
- `resp_result`  out  XLEN  registered ALU result, shared by both ports.
- `resp_lsb`  out  1  registered result bit 0.
- `resp_eq_zero`  out  1  registered (result == 0).

## Operation
- Output register state machine with two states:
  - EMPTY: `resp*_valid`=0.
  - FULL: the register holds one result and its owner id (0/1).
- Drain: in FULL, `drain` = the owner's `resp*_ready` is high.
- Can-accept condition: `accept_ok` = EMPTY or (FULL and `drain`).
- Grant: when `accept_ok` is high, exactly one valid requester is granted.
  - If only one port is valid, that port is granted.
  - If both are valid, the port chosen by the arbitration policy (see Configuration) is granted.
- `reqN_ready` is combinational: high only for the granted port.
- The loser sees ready=0 and must hold its valid and payload stable.
- On grant:
  - The ALU is fed the winner's function/a/b.
  - `resp_result`, `resp_lsb` and `resp_eq_zero` are registered.
  - The owner is set to the winner.
  - The state becomes FULL.
- FULL with `drain` and no grant: the state becomes EMPTY.
- FULL without `drain`: the register and owner hold; no grant is issued.
- Simultaneous drain and grant: the register is overwritten and the state stays FULL. There is no bubble.
- `resp*_ready` of the non-owner port is ignored.
- Reset (asynchronous, may arrive mid-operation):
  - State is EMPTY.
  - `resp*_valid`=0 and `resp_result`=0.
  - `resp_lsb`=0.
  - `resp_eq_zero`=0.
  - Owner and round-robin pointer are 0.
  - An in-flight result is discarded.

## Timing
- Latency: a request accepted at edge k has its response valid from edge k+1.
- Throughput: one operation per cycle when the owner drains every cycle.
- `reqN_ready` depends combinationally on `reqN_valid` and the owner's `resp*_ready`. There is no combinational path from `req*` payload to `resp*` outputs.
- ALU evaluation is purely combinational within the accept cycle.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration using a 1-bit pointer that names the preferred port.
  - When both ports are valid and a grant occurs, the preferred port wins and the pointer flips to the other port.
  - A single-requester grant sets the pointer to the non-granted port.
- Undefined: fixed priority, port 0 always wins when both ports are valid. The pointer register is not built.

## Structure
- Shared package `alu_pkg`:
  - ALU function-code constants `ALU_ADD_SUB`, `ALU_SLL`, `ALU_SLT`, `ALU_SLTU`, `ALU_XOR`, `ALU_SHIFTR`, `ALU_OR`, `ALU_AND`.
  - Modifier bit positions: bit 3 selects SUB/SRA, bit 4 selects the 32-bit shift range.
  - Requester id type (1 bit).
- One sub-module, the existing `alu`, instantiated once and fed by the grant mux.
- The arbiter and the output register live in this block.

## Test plan
- Reset mid-FULL: load port 0 with ADD 5+7, assert `rst_n`=0 before draining -> `resp0_valid`=0, `resp_result`=0, `req0_ready` follows `req0_valid` after release.
- Single port: port 1 issues SUB (function 5'b01000), a=3, b=3 -> next cycle `resp1_valid`=1, `resp_result`=0, `resp_eq_zero`=1, `resp0_valid`=0.
- Contention with `ALU_ARB_ROUND_ROBIN_EN`:
  - Stimulus: both ports valid for 4 cycles, owners always ready.
  - Required: grants go 0,1,0,1.
  - Without the macro: grants go 0,0,0,0 and `req1_ready` stays 0.
- Backpressure: port 0 XOR 0xF0^0x0F with `resp0_ready`=0 for 3 cycles and port 1 valid -> `resp_result`=0xFF held; `req1_ready`=0 until the drain cycle, then port 1 is granted the same cycle.
- Back-to-back: port 0 issues SLL a=1, b=63, then SLL with function bit 4 set, b=33 (uses b[4:0]=1), drained every cycle -> results 0x8000000000000000 then 0x2 on consecutive cycles, no bubble.
- Non-owner ready: FULL owned by port 1, `resp0_ready`=1, `resp1_ready`=0 -> state stays FULL and the result is unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-code constants, modifier bit positions,
// requester id and output-register state types.
package alu_pkg;

    // Operation field, function[2:0]
    localparam logic [2:0] ALU_ADD_SUB = 3'd0;
    localparam logic [2:0] ALU_SLL     = 3'd1;
    localparam logic [2:0] ALU_SLT     = 3'd2;
    localparam logic [2:0] ALU_SLTU    = 3'd3;
    localparam logic [2:0] ALU_XOR     = 3'd4;
    localparam logic [2:0] ALU_SHIFTR  = 3'd5;
    localparam logic [2:0] ALU_OR      = 3'd6;
    localparam logic [2:0] ALU_AND     = 3'd7;

    // Modifier bits: SUB/SRA select, and 32-bit shift range (shamt = b[4:0])
    localparam int ALU_MOD_SUB_BIT = 3;
    localparam int ALU_MOD_W32_BIT = 4;

    typedef logic req_id_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Purely combinational RV64I ALU; function[2:0] selects the operation,
// bit 3 selects SUB/SRA and bit 4 limits the shift amount to b[4:0].
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]         shamt;
    logic signed [XLEN-1:0] sra;

    always_comb begin
        shamt = func[ALU_MOD_W32_BIT] ? {1'b0, b[4:0]} : b[SHW-1:0];
        sra   = $signed(a) >>> shamt;
        y     = '0;
        case (func[2:0])
            ALU_ADD_SUB: y = func[ALU_MOD_SUB_BIT] ? a - b : a + b;
            ALU_SLL:     y = a << shamt;
            ALU_SLT:     y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:    y = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:     y = a ^ b;
            ALU_SHIFTR:  y = func[ALU_MOD_SUB_BIT] ? $unsigned(sra) : a >> shamt;
            ALU_OR:      y = a | b;
            ALU_AND:     y = a & b;
            default:     y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared ALU with a single registered result.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [4:0]      req0_function,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [4:0]      req1_function,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_lsb,
    output logic            resp_eq_zero,
    output arb_state_e      state_dbg
);

    // Handshake: a transfer happens on an edge where valid && ready are both
    // high; a requester holding valid must keep its payload stable until ready.

    arb_state_e      state_q, state_d;
    req_id_t         owner_q;
    req_id_t         winner;
    req_id_t         pref;
    logic [XLEN-1:0] result_q;
    logic            lsb_q, eqz_q;
    logic            drain, accept_ok, grant;
    logic [4:0]      alu_func;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    req_id_t rr_ptr_q;

    // The port not granted this time becomes the preferred one next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rr_ptr_q <= 1'b0;
        else if (grant) rr_ptr_q <= ~winner;
    end

    assign pref = rr_ptr_q;
`else
    assign pref = 1'b0;
`endif

    always_comb begin
        drain     = (state_q == ST_FULL) && (owner_q ? resp1_ready : resp0_ready);
        accept_ok = (state_q == ST_EMPTY) || drain;
        winner    = (req0_valid && req1_valid) ? pref : req1_valid;
        grant     = accept_ok && (req0_valid || req1_valid);
        alu_func  = winner ? req1_function : req0_function;
        alu_a     = winner ? req1_a : req0_a;
        alu_b     = winner ? req1_b : req0_b;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .func (alu_func),
        .a    (alu_a),
        .b    (alu_b),
        .y    (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant) state_d = ST_FULL;
            ST_FULL: begin
                if (grant)      state_d = ST_FULL;
                else if (drain) state_d = ST_EMPTY;
            end
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        resp0_valid = (state_q == ST_FULL) && (owner_q == 1'b0);
        resp1_valid = (state_q == ST_FULL) && (owner_q == 1'b1);
        req0_ready  = grant && (winner == 1'b0);
        req1_ready  = grant && (winner == 1'b1);
        state_dbg   = state_q;
    end

    // Result register is overwritten on every grant, including drain+grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            lsb_q    <= 1'b0;
            eqz_q    <= 1'b0;
            owner_q  <= 1'b0;
        end else if (grant) begin
            result_q <= alu_y;
            lsb_q    <= alu_y[0];
            eqz_q    <= (alu_y == '0);
            owner_q  <= winner;
        end
    end

    assign resp_result  = result_q;
    assign resp_lsb     = lsb_q;
    assign resp_eq_zero = eqz_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_alu_share_arbiter;

    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_function, req1_function;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [63:0] resp_result;
    logic        resp_lsb, resp_eq_zero;
    alu_pkg::arb_state_e state_dbg;

    // clock / reset
    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_function (req0_function),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_function (req1_function),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .resp0_valid   (resp0_valid),
        .resp0_ready   (resp0_ready),
        .resp1_valid   (resp1_valid),
        .resp1_ready   (resp1_ready),
        .resp_result   (resp_result),
        .resp_lsb      (resp_lsb),
        .resp_eq_zero  (resp_eq_zero),
        .state_dbg     (state_dbg)
    );

    // scoreboard: the held result (at most one) and its owner
    logic [63:0] exp_q[$];
    bit          own_q[$];
    bit          m_ptr;
    bit          m_g0, m_g1;
    bit          obs_r0, obs_r1;
    int          total = 0;
    int          bad = 0;
    int          gseq[4];
    int          exp_g[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [4:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
        int          sh;
        logic [63:0] r;
        sh = f[4] ? int'(b % 64'd32) : int'(b % 64'd64);
        case (f[2:0])
            3'd0: r = f[3] ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = {63'd0, (a ^ MSB) < (b ^ MSB)};
            3'd3: r = {63'd0, a < b};
            3'd4: r = a ^ b;
            3'd5: begin
                r = a >> sh;
                if (f[3] && a[63]) r = r | ~(ALL1 >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // driver tasks
    task automatic set_req(input int p, input logic v, input logic [4:0] f,
                           input logic [63:0] a, input logic [63:0] b);
        if (p == 0) begin
            req0_valid = v; req0_function = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_function = f; req1_a = a; req1_b = b;
        end
    endtask

    task automatic rand_port(input int p);
        logic [4:0]  f;
        logic [63:0] a, b;
        f = 5'($urandom_range(0, 31));
        a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        set_req(p, $urandom_range(0, 3) != 0, f, a, b);
    endtask

    // Called at posedge+1; async reset asserted and released between edges.
    task automatic apply_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_resp0_valid", 64'(resp0_valid), 64'd0);
        check("rst_resp1_valid", 64'(resp1_valid), 64'd0);
        check("rst_result", resp_result, 64'd0);
        check("rst_lsb", 64'(resp_lsb), 64'd0);
        check("rst_eq_zero", 64'(resp_eq_zero), 64'd0);
        exp_q.delete();
        own_q.delete();
        m_ptr = 1'b0;
        m_g0  = 1'b0;
        m_g1  = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    // One clock: check at negedge against the model, advance model after posedge.
    task automatic cycle();
        bit          full, own, drain, acc, win, grant, pref;
        logic [63:0] e, nv;
        @(negedge clk);
        full  = exp_q.size() != 0;
        own   = full ? own_q[0] : 1'b0;
        drain = full && (own ? resp1_ready : resp0_ready);
        acc   = !full || drain;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        pref  = m_ptr;
`else
        pref  = 1'b0;
`endif
        win   = (req0_valid && req1_valid) ? pref : req1_valid;
        grant = acc && (req0_valid || req1_valid);
        nv    = win ? ref_alu(req1_function, req1_a, req1_b)
                    : ref_alu(req0_function, req0_a, req0_b);
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        check("req0_ready", 64'(req0_ready), 64'(grant && !win));
        check("req1_ready", 64'(req1_ready), 64'(grant && win));
        check("resp0_valid", 64'(resp0_valid), 64'(full && !own));
        check("resp1_valid", 64'(resp1_valid), 64'(full && own));
        if (full) begin
            e = exp_q[0];
            check("resp_result", resp_result, e);
            check("resp_lsb", 64'(resp_lsb), 64'(e[0]));
            check("resp_eq_zero", 64'(resp_eq_zero), 64'(e == 64'd0));
        end
        @(posedge clk);
        #1;
        if (drain) begin
            void'(exp_q.pop_front());
            void'(own_q.pop_front());
        end
        if (grant) begin
            exp_q.push_back(nv);
            own_q.push_back(win);
            m_ptr = !win;
        end
        m_g0 = grant && !win;
        m_g1 = grant && win;
    endtask

    initial begin
        rst_n = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
        set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        apply_reset();

        // reset while FULL discards the held result
        set_req(0, 1'b1, 5'd0, 64'd5, 64'd7);
        cycle();
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
        cycle();
        check("midfull_result", resp_result, 64'd12);
        apply_reset();
        set_req(0, 1'b1, 5'd0, 64'd1, 64'd1);
        cycle();
        check("post_rst_req0_ready", 64'(obs_r0), 64'd1);
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);

        // single port SUB 3-3
        apply_reset();
        set_req(1, 1'b1, 5'b01000, 64'd3, 64'd3);
        cycle();
        set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
        check("sub_resp1_valid", 64'(resp1_valid), 64'd1);
        check("sub_resp0_valid", 64'(resp0_valid), 64'd0);
        check("sub_result", resp_result, 64'd0);
        check("sub_eq_zero", 64'(resp_eq_zero), 64'd1);

        // contention, owners always ready
        apply_reset();
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        set_req(0, 1'b1, 5'd0, 64'd1, 64'd1);
        set_req(1, 1'b1, 5'd0, 64'd2, 64'd2);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("cont_one_grant", 64'(obs_r0 ^ obs_r1), 64'd1);
            gseq[k] = obs_r1 ? 1 : 0;
        end
        for (int k = 0; k < 4; k++) check("cont_grant_seq", 64'(gseq[k]), 64'(exp_g[k]));
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
        set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);

        // backpressure on port 0 blocks port 1 until the drain cycle
        apply_reset();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        set_req(0, 1'b1, 5'd4, 64'hF0, 64'h0F);
        cycle();
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);
        set_req(1, 1'b1, 5'd0, 64'd10, 64'd20);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_req1_ready", 64'(obs_r1), 64'd0);
            check("bp_result", resp_result, 64'hFF);
        end
        resp0_ready = 1'b1;
        cycle();
        check("bp_drain_grant", 64'(obs_r1), 64'd1);
        set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
        check("bp_resp1_valid", 64'(resp1_valid), 64'd1);
        check("bp_resp1_result", resp_result, 64'd30);

        // back-to-back shifts, drained every cycle
        apply_reset();
        resp0_ready = 1'b1;
        set_req(0, 1'b1, 5'd1, 64'd1, 64'd63);
        cycle();
        check("b2b_result1", resp_result, 64'h8000_0000_0000_0000);
        set_req(0, 1'b1, 5'b10001, 64'd1, 64'd33);
        cycle();
        check("b2b_ready2", 64'(obs_r0), 64'd1);
        check("b2b_result2", resp_result, 64'd2);
        check("b2b_valid2", 64'(resp0_valid), 64'd1);
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);

        // non-owner ready is ignored
        apply_reset();
        resp0_ready = 1'b1;
        resp1_ready = 1'b0;
        set_req(1, 1'b1, 5'd6, 64'h5, 64'h30);
        cycle();
        set_req(1, 1'b0, 5'd0, 64'd0, 64'd0);
        set_req(0, 1'b1, 5'd0, 64'd9, 64'd9);
        cycle();
        cycle();
        check("nonown_req0_ready", 64'(obs_r0), 64'd0);
        check("nonown_resp1_valid", 64'(resp1_valid), 64'd1);
        check("nonown_result", resp_result, 64'h35);
        set_req(0, 1'b0, 5'd0, 64'd0, 64'd0);

        // randomized traffic; a requester that was not granted holds its payload
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 250) apply_reset();
            if (!(req0_valid && !m_g0)) rand_port(0);
            if (!(req1_valid && !m_g1)) rand_port(1);
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
